// File: rtl/dual_issue_ctrl.sv
// Issue control between dual decode and the two-lane execute stage.
// Splits intra-pair RAW pairs, inserts load-use bubbles, and registers per-lane issue info.
module dual_issue_ctrl #(
  parameter int REG_AW = 5,
  parameter int ALU_W  = 5,
  parameter int TYPE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [TYPE_W-1:0] id_type_a,
  input  logic [TYPE_W-1:0] id_type_b,
  input  logic [ALU_W-1:0]  id_alu_a,
  input  logic [ALU_W-1:0]  id_alu_b,
  input  logic [REG_AW-1:0] id_rd_a,
  input  logic [REG_AW-1:0] id_rd_b,
  input  logic [REG_AW-1:0] id_rs1_a,
  input  logic [REG_AW-1:0] id_rs1_b,
  input  logic [REG_AW-1:0] id_rs2_a,
  input  logic [REG_AW-1:0] id_rs2_b,
  input  logic              ex_stall,
  output logic              ex_valid_a,
  output logic              ex_valid_b,
  output logic [TYPE_W-1:0] ex_type_a,
  output logic [TYPE_W-1:0] ex_type_b,
  output logic [ALU_W-1:0]  ex_alu_a,
  output logic [ALU_W-1:0]  ex_alu_b,
  output logic [REG_AW-1:0] ex_rd_a,
  output logic [REG_AW-1:0] ex_rd_b,
  output logic [TYPE_W-1:0] ex_haz_a,
  output logic [TYPE_W-1:0] ex_haz_b
);
  localparam logic [TYPE_W-1:0] T_R = 4'h0, T_IMM = 4'h1, T_LOAD = 4'h2, T_S = 4'h3, T_B = 4'h4,
    T_JAL = 4'h5, T_JALR = 4'h6, T_LUI = 4'h7, T_AUIPC = 4'h8, T_NOP = 4'hA, T_NONE = 4'hB;
  localparam logic [TYPE_W-1:0] HZ_A_STALL = 4'h0, HZ_B_STALL = 4'h1, HZ_STALL_FROM_A = 4'h2,
    HZ_FORW_FROM_A = 4'h8, HZ_NONE = 4'h9;
  localparam logic [ALU_W-1:0] ALU_IDLE = '1;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [ALU_W-1:0]  alu;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } slot_t;

  typedef struct packed {
    logic              v;
    logic [TYPE_W-1:0] typ;
    logic [ALU_W-1:0]  alu;
    logic [REG_AW-1:0] rd;
    logic [TYPE_W-1:0] haz;
  } lane_t;

  typedef enum logic [1:0] {ST_ISSUE, ST_LU_STALL, ST_SPLIT, ST_SPLIT_LU} state_t;

  function automatic logic writes(slot_t s);
    logic w;
    case (s.typ)
      T_R, T_IMM, T_LOAD, T_JAL, T_JALR, T_LUI, T_AUIPC: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w && (s.rd != '0);
  endfunction

  // x0 is never a dependency source, so r==0 never matches.
  function automatic logic reads(slot_t s, logic [REG_AW-1:0] r);
    logic u1, u2;
    case (s.typ)
      T_R, T_S, T_B:         begin u1 = 1'b1; u2 = 1'b1; end
      T_IMM, T_LOAD, T_JALR: begin u1 = 1'b1; u2 = 1'b0; end
      default:               begin u1 = 1'b0; u2 = 1'b0; end
    endcase
    return (r != '0) && ((u1 && s.rs1 == r) || (u2 && s.rs2 == r));
  endfunction

  function automatic lane_t bubble(logic [TYPE_W-1:0] haz);
    return '{v: 1'b0, typ: T_NOP, alu: ALU_IDLE, rd: '0, haz: haz};
  endfunction

  function automatic lane_t issue(slot_t s, logic [TYPE_W-1:0] haz);
    return '{v: (s.typ != T_NOP) && (s.typ != T_NONE), typ: s.typ, alu: s.alu, rd: s.rd, haz: haz};
  endfunction

  state_t state, state_n;
  slot_t  lat_a, lat_b, lat_a_n, lat_b_n, id_a, id_b, cur_a, cur_b;
  lane_t  ln_a, ln_b, ln_a_n, ln_b_n;
  logic [1:0]             lu_vld, lu_vld_n;
  logic [1:0][REG_AW-1:0] lu_rd;
  logic accept, intra, lu_a, lu_b, go;

  assign id_a = '{typ: id_type_a, alu: id_alu_a, rd: id_rd_a, rs1: id_rs1_a, rs2: id_rs2_a};
  assign id_b = '{typ: id_type_b, alu: id_alu_b, rd: id_rd_b, rs1: id_rs1_b, rs2: id_rs2_b};

  assign id_ready = !reset && !ex_stall && (state == ST_ISSUE);
  assign accept   = id_valid && id_ready;

  assign cur_a = (state == ST_LU_STALL) ? lat_a : id_a;
  assign cur_b = (state == ST_LU_STALL) ? lat_b : id_b;
  assign intra = writes(cur_a) && reads(cur_b, cur_a.rd);
  assign lu_a  = (lu_vld[0] && reads(id_a, lu_rd[0])) || (lu_vld[1] && reads(id_a, lu_rd[1]));
  assign lu_b  = (lu_vld[0] && reads(id_b, lu_rd[0])) || (lu_vld[1] && reads(id_b, lu_rd[1]));

  always_comb begin
    state_n = state;
    lat_a_n = lat_a;
    lat_b_n = lat_b;
    ln_a_n  = bubble(HZ_NONE);
    ln_b_n  = bubble(HZ_NONE);
    go      = 1'b0;
    case (state)
      ST_ISSUE:
        if (accept) begin
          if (lu_a || lu_b) begin
            lat_a_n    = id_a;
            lat_b_n    = id_b;
            ln_a_n.haz = lu_a ? HZ_A_STALL : HZ_NONE;
            ln_b_n.haz = lu_b ? HZ_B_STALL : HZ_NONE;
            state_n    = ST_LU_STALL;
          end else go = 1'b1;
        end
      ST_LU_STALL: go = 1'b1;
      ST_SPLIT: begin
        ln_b_n  = issue(lat_b, HZ_FORW_FROM_A);
        state_n = ST_ISSUE;
      end
      ST_SPLIT_LU: begin
        ln_b_n.haz = HZ_B_STALL;
        state_n    = ST_SPLIT;
      end
      default: state_n = ST_ISSUE;
    endcase
    if (go) begin
      ln_a_n = issue(cur_a, HZ_NONE);
      if (intra) begin
        ln_b_n.haz = HZ_STALL_FROM_A;
        lat_b_n    = cur_b;
        state_n    = (cur_a.typ == T_LOAD) ? ST_SPLIT_LU : ST_SPLIT;
      end else begin
        ln_b_n  = issue(cur_b, HZ_NONE);
        state_n = ST_ISSUE;
      end
    end
  end

  // Tracker holds only what was issued this cycle, so a bubble empties it.
  assign lu_vld_n[0] = ln_a_n.v && (ln_a_n.typ == T_LOAD) && (ln_a_n.rd != '0);
  assign lu_vld_n[1] = ln_b_n.v && (ln_b_n.typ == T_LOAD) && (ln_b_n.rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_ISSUE;
      lat_a  <= '0;
      lat_b  <= '0;
      ln_a   <= bubble(HZ_NONE);
      ln_b   <= bubble(HZ_NONE);
      lu_vld <= '0;
      lu_rd  <= '0;
    end else if (!ex_stall) begin
      state  <= state_n;
      lat_a  <= lat_a_n;
      lat_b  <= lat_b_n;
      ln_a   <= ln_a_n;
      ln_b   <= ln_b_n;
      lu_vld <= lu_vld_n;
      lu_rd  <= {ln_b_n.rd, ln_a_n.rd};
    end
  end

  assign ex_valid_a = ln_a.v;
  assign ex_type_a  = ln_a.typ;
  assign ex_alu_a   = ln_a.alu;
  assign ex_rd_a    = ln_a.rd;
  assign ex_haz_a   = ln_a.haz;
  assign ex_valid_b = ln_b.v;
  assign ex_type_b  = ln_b.typ;
  assign ex_alu_b   = ln_b.alu;
  assign ex_rd_b    = ln_b.rd;
  assign ex_haz_b   = ln_b.haz;
endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scenario bench for dual_issue_ctrl: each cycle pushes its expected EX result, compared after the edge.
module tb_dual_issue_ctrl;
  logic       clk = 1'b0;
  logic       reset, id_valid, id_ready, ex_stall;
  logic [3:0] id_type_a, id_type_b, ex_type_a, ex_type_b, ex_haz_a, ex_haz_b;
  logic [4:0] id_alu_a, id_alu_b, id_rd_a, id_rd_b, id_rs1_a, id_rs1_b, id_rs2_a, id_rs2_b;
  logic [4:0] ex_alu_a, ex_alu_b, ex_rd_a, ex_rd_b;
  logic       ex_valid_a, ex_valid_b;

  always #5 clk = ~clk;

  dual_issue_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_type_a(id_type_a), .id_type_b(id_type_b), .id_alu_a(id_alu_a), .id_alu_b(id_alu_b),
    .id_rd_a(id_rd_a), .id_rd_b(id_rd_b), .id_rs1_a(id_rs1_a), .id_rs1_b(id_rs1_b),
    .id_rs2_a(id_rs2_a), .id_rs2_b(id_rs2_b), .ex_stall(ex_stall),
    .ex_valid_a(ex_valid_a), .ex_valid_b(ex_valid_b), .ex_type_a(ex_type_a), .ex_type_b(ex_type_b),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_rd_a(ex_rd_a), .ex_rd_b(ex_rd_b),
    .ex_haz_a(ex_haz_a), .ex_haz_b(ex_haz_b)
  );

  typedef struct packed {
    logic [3:0] typ;
    logic [4:0] alu, rd, rs1, rs2;
  } slot_t;

  typedef struct packed {
    logic       v;
    logic [3:0] typ;
    logic [4:0] alu, rd;
    logic [3:0] haz;
  } lane_t;

  typedef struct packed { lane_t a, b; } exp_t;

  exp_t q[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic slot_t sl(logic [3:0] t, logic [4:0] alu, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
    return '{typ: t, alu: alu, rd: rd, rs1: r1, rs2: r2};
  endfunction

  function automatic lane_t iss(slot_t s, logic [3:0] haz);
    return '{v: (s.typ != 4'hA) && (s.typ != 4'hB), typ: s.typ, alu: s.alu, rd: s.rd, haz: haz};
  endfunction

  function automatic lane_t bub(logic [3:0] haz);
    return '{v: 1'b0, typ: 4'hA, alu: 5'h1F, rd: 5'd0, haz: haz};
  endfunction

  function automatic exp_t ex(lane_t a, lane_t b);
    return '{a: a, b: b};
  endfunction

  // One cycle: drive at negedge, check id_ready, push expectation, compare after the edge.
  task automatic cyc(input string tag, input logic rst, input logic v, input logic stall,
                     input slot_t a, input slot_t b, input logic rdy, input exp_t e);
    exp_t g;
    reset = rst; id_valid = v; ex_stall = stall;
    id_type_a = a.typ; id_alu_a = a.alu; id_rd_a = a.rd; id_rs1_a = a.rs1; id_rs2_a = a.rs2;
    id_type_b = b.typ; id_alu_b = b.alu; id_rd_b = b.rd; id_rs1_b = b.rs1; id_rs2_b = b.rs2;
    #1;
    chk({tag, ".rdy"}, int'(id_ready), int'(rdy));
    q.push_back(e);
    last = e;
    @(posedge clk);
    @(negedge clk);
    g = q.pop_front();
    chk({tag, ".va"},  int'(ex_valid_a), int'(g.a.v));
    chk({tag, ".ta"},  int'(ex_type_a),  int'(g.a.typ));
    chk({tag, ".aa"},  int'(ex_alu_a),   int'(g.a.alu));
    chk({tag, ".rda"}, int'(ex_rd_a),    int'(g.a.rd));
    chk({tag, ".ha"},  int'(ex_haz_a),   int'(g.a.haz));
    chk({tag, ".vb"},  int'(ex_valid_b), int'(g.b.v));
    chk({tag, ".tb"},  int'(ex_type_b),  int'(g.b.typ));
    chk({tag, ".ab"},  int'(ex_alu_b),   int'(g.b.alu));
    chk({tag, ".rdb"}, int'(ex_rd_b),    int'(g.b.rd));
    chk({tag, ".hb"},  int'(ex_haz_b),   int'(g.b.haz));
  endtask

  initial begin
    slot_t z, a, b, j, a2, b2;
    exp_t  idle, hold;
    z    = sl(4'hB, 5'd0, 5'd0, 5'd0, 5'd0);
    j    = sl(4'h0, 5'd9, 5'd30, 5'd29, 5'd28);
    idle = ex(bub(4'h9), bub(4'h9));
    @(negedge clk);

    cyc("rst0", 1, 0, 0, z, z, 0, idle);
    cyc("rst1", 1, 0, 0, z, z, 0, idle);
    cyc("idle", 0, 0, 0, z, z, 1, idle);

    // Independent pair issues whole
    a = sl(4'h0, 5'd0, 5'd1, 5'd2, 5'd3); b = sl(4'h0, 5'd0, 5'd4, 5'd5, 5'd6);
    cyc("pair", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), iss(b, 4'h9)));
    cyc("pair.i", 0, 0, 0, z, z, 1, idle);

    // Intra RAW split; junk pair offered while busy must not be taken
    a = sl(4'h0, 5'd0, 5'd1, 5'd2, 5'd3); b = sl(4'h0, 5'd1, 5'd7, 5'd1, 5'd2);
    cyc("spl0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), bub(4'h2)));
    cyc("spl1", 0, 1, 0, j, j, 0, ex(bub(4'h9), iss(b, 4'h8)));
    cyc("spl2", 0, 0, 0, z, z, 1, idle);

    // Load-use across pairs, consumer in slot B
    a = sl(4'h2, 5'd0, 5'd5, 5'd1, 5'd0); b = sl(4'h0, 5'd0, 5'd8, 5'd9, 5'd10);
    cyc("lu0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), iss(b, 4'h9)));
    a2 = sl(4'h0, 5'd0, 5'd11, 5'd12, 5'd13); b2 = sl(4'h0, 5'd2, 5'd14, 5'd5, 5'd6);
    cyc("lu1", 0, 1, 0, a2, b2, 1, ex(bub(4'h9), bub(4'h1)));
    cyc("lu2", 0, 1, 0, j, j, 0, ex(iss(a2, 4'h9), iss(b2, 4'h9)));
    cyc("lu3", 0, 0, 0, z, z, 1, idle);

    // Load-use, producer in lane B, consumer in slot A
    a = sl(4'h0, 5'd0, 5'd20, 5'd1, 5'd1); b = sl(4'h2, 5'd0, 5'd6, 5'd1, 5'd0);
    cyc("lua0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), iss(b, 4'h9)));
    a2 = sl(4'h0, 5'd0, 5'd21, 5'd6, 5'd0); b2 = sl(4'h0, 5'd0, 5'd22, 5'd1, 5'd1);
    cyc("lua1", 0, 1, 0, a2, b2, 1, ex(bub(4'h0), bub(4'h9)));
    cyc("lua2", 0, 0, 0, z, z, 0, ex(iss(a2, 4'h9), iss(b2, 4'h9)));
    cyc("lua3", 0, 0, 0, z, z, 1, idle);

    // Intra pair with load producer: extra bubble before B
    a = sl(4'h2, 5'd0, 5'd3, 5'd1, 5'd0); b = sl(4'h0, 5'd0, 5'd4, 5'd3, 5'd0);
    cyc("sl0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), bub(4'h2)));
    cyc("sl1", 0, 0, 0, z, z, 0, ex(bub(4'h9), bub(4'h1)));
    cyc("sl2", 0, 0, 0, z, z, 0, ex(bub(4'h9), iss(b, 4'h8)));
    cyc("sl3", 0, 0, 0, z, z, 1, idle);

    // x0 write never creates a dependency
    a = sl(4'h1, 5'd0, 5'd0, 5'd1, 5'd0); b = sl(4'h0, 5'd0, 5'd2, 5'd0, 5'd0);
    cyc("x0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), iss(b, 4'h9)));

    // NOP slot forwarded invalid, no hazard on the reused rd
    a = sl(4'hA, 5'd3, 5'd9, 5'd0, 5'd0); b = sl(4'h0, 5'd4, 5'd10, 5'd9, 5'd9);
    cyc("nop", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), iss(b, 4'h9)));

    // EX stall mid-split freezes everything
    a = sl(4'h0, 5'd0, 5'd1, 5'd2, 5'd3); b = sl(4'h0, 5'd1, 5'd7, 5'd1, 5'd2);
    cyc("st0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), bub(4'h2)));
    hold = last;
    for (int k = 0; k < 3; k++) cyc("stl", 0, 1, 1, j, j, 0, hold);
    cyc("st4", 0, 0, 0, z, z, 0, ex(bub(4'h9), iss(b, 4'h8)));
    cyc("st5", 0, 0, 0, z, z, 1, idle);

    // Reset during a split drops the latched slot
    cyc("rm0", 0, 1, 0, a, b, 1, ex(iss(a, 4'h9), bub(4'h2)));
    cyc("rm1", 1, 0, 0, z, z, 0, idle);
    cyc("rm2", 0, 0, 0, z, z, 1, idle);
    cyc("rm3", 0, 0, 0, z, z, 1, idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
